// File: rtl/eq_search_ctrl.sv
// Sequential equality search over a small valid-tagged table using one shared comparator.
// Optional match counter (full-table scan) enabled by defining EQ_SEARCH_COUNT_EN.
module eq_search_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [IDX_W-1:0] WR_ADDR,
  input  logic [15:0]      WR_DATA,
  input  logic             START,
  input  logic [15:0]      CHAVE,
  output logic             BUSY,
  output logic             DONE,
  output logic             HIT,
`ifdef EQ_SEARCH_COUNT_EN
  output logic [IDX_W-1:0] INDICE,
  output logic [IDX_W:0]   CONTAGEM
`else
  output logic [IDX_W-1:0] INDICE
`endif
);

  typedef enum logic [1:0] {StOcioso, StBusca, StFim} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [15:0]      key_q, key_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [DEPTH-1:0] valid_q;
  logic [15:0]      mem_q [DEPTH];
`ifdef EQ_SEARCH_COUNT_EN
  logic [IDX_W:0]   cnt_q, cnt_d;
`endif

  logic wr_ok;
  logic match;
  logic last;

  // The table only accepts writes while idle so a running search sees a frozen snapshot.
  assign wr_ok = WR_EN && (state_q == StOcioso);
  assign match = valid_q[ptr_q] && (mem_q[ptr_q] == key_q);
  assign last  = (ptr_q == IDX_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    key_d   = key_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef EQ_SEARCH_COUNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StOcioso: begin
        if (START) begin
          key_d   = CHAVE;
          hit_d   = 1'b0;
          idx_d   = '0;
          ptr_d   = '0;
`ifdef EQ_SEARCH_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = StBusca;
        end
      end
      StBusca: begin
        if (match && !hit_q) begin
          hit_d = 1'b1;
          idx_d = ptr_q;
        end
`ifdef EQ_SEARCH_COUNT_EN
        if (match) cnt_d = cnt_q + 1'b1;
        if (last) state_d = StFim;
        else      ptr_d   = ptr_q + 1'b1;
`else
        if (match || last) state_d = StFim;
        else               ptr_d   = ptr_q + 1'b1;
`endif
      end
      StFim: begin
        done_d  = 1'b1;
        state_d = StOcioso;
      end
      default: state_d = StOcioso;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StOcioso;
      ptr_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
`ifdef EQ_SEARCH_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (wr_ok) valid_q[WR_ADDR] <= 1'b1;
`ifdef EQ_SEARCH_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Entry data needs no reset; the valid bits gate every match.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[WR_ADDR] <= WR_DATA;
  end

  assign BUSY   = (state_q != StOcioso);
  assign DONE   = done_q;
  assign HIT    = hit_q;
  assign INDICE = idx_q;
`ifdef EQ_SEARCH_COUNT_EN
  assign CONTAGEM = cnt_q;
`endif

endmodule

// File: tb/tb_eq_search_ctrl.sv
// Self-checking bench for eq_search_ctrl: directed scenarios plus randomized table/key rounds
// compared against a plain array model of the table.
module tb_eq_search_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             WR_EN;
  logic [IDX_W-1:0] WR_ADDR;
  logic [15:0]      WR_DATA;
  logic             START;
  logic [15:0]      CHAVE;
  logic             BUSY;
  logic             DONE;
  logic             HIT;
  logic [IDX_W-1:0] INDICE;
`ifdef EQ_SEARCH_COUNT_EN
  logic [IDX_W:0]   CONTAGEM;
`endif

  eq_search_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .START    (START),
    .CHAVE    (CHAVE),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .HIT      (HIT),
`ifdef EQ_SEARCH_COUNT_EN
    .INDICE   (INDICE),
    .CONTAGEM (CONTAGEM)
`else
    .INDICE   (INDICE)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem_m [DEPTH];
  bit          vld_m [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: lowest valid entry equal to key, and how many valid entries equal it.
  task automatic model_search(input logic [15:0] key, output int idx, output int cnt);
    idx = -1;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_m[i] && mem_m[i] == key) begin
        if (idx < 0) idx = i;
        cnt++;
      end
    end
  endtask

  task automatic write_entry(input int addr, input logic [15:0] data);
    WR_EN   = 1'b1;
    WR_ADDR = IDX_W'(addr);
    WR_DATA = data;
    @(posedge CLK); #1;
    WR_EN   = 1'b0;
    mem_m[addr] = data;
    vld_m[addr] = 1'b1;
  endtask

  // mode 0: plain search; 1: write+START injected while busy; 2: reset in cycle 3;
  // 3: write entry 0 with wdata in the same cycle as START.
  task automatic run_search(input string tag, input logic [15:0] key, input int mode,
                            input logic [15:0] wdata);
    int exp_idx, exp_cnt, exp_lat, lat;
    if (mode == 3) begin
      mem_m[0] = wdata;
      vld_m[0] = 1'b1;
    end
    model_search(key, exp_idx, exp_cnt);
`ifdef EQ_SEARCH_COUNT_EN
    exp_lat = DEPTH + 1;
`else
    exp_lat = (exp_idx >= 0) ? exp_idx + 2 : DEPTH + 1;
`endif
    START = 1'b1;
    CHAVE = key;
    if (mode == 3) begin
      WR_EN   = 1'b1;
      WR_ADDR = '0;
      WR_DATA = wdata;
    end
    @(posedge CLK); #1;
    START = 1'b0;
    WR_EN = 1'b0;
    check_eq({tag, "_busy0"}, 32'(BUSY), 32'd1);
    lat = 0;
    for (int c = 1; c <= DEPTH + 4 && lat == 0; c++) begin
      if (mode == 1 && c == 2) begin
        WR_EN   = 1'b1;
        WR_ADDR = IDX_W'(7);
        WR_DATA = key;
        START   = 1'b1;
      end
      if (mode == 2 && c == 3) RST_N = 1'b0;
      @(posedge CLK); #1;
      WR_EN = 1'b0;
      START = 1'b0;
      RST_N = 1'b1;
      if (mode == 2 && c == 3) begin
        check_eq({tag, "_busy_after_rst"}, 32'(BUSY), 32'd0);
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
      end
      if (DONE) lat = c;
    end
    if (mode == 2) begin
      check_eq({tag, "_no_done"}, 32'(lat), 32'd0);
      check_eq({tag, "_hit_rst"}, 32'(HIT), 32'd0);
      return;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_hit"}, 32'(HIT), (exp_idx >= 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_idx"}, 32'(INDICE), (exp_idx >= 0) ? 32'(exp_idx) : 32'd0);
`ifdef EQ_SEARCH_COUNT_EN
    check_eq({tag, "_cnt"}, 32'(CONTAGEM), 32'(exp_cnt));
`endif
    // DONE is a single pulse and results hold while idle.
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check_eq({tag, "_done_lo"}, 32'(DONE), 32'd0);
    end
    check_eq({tag, "_idle"}, 32'(BUSY), 32'd0);
    check_eq({tag, "_hit_hold"}, 32'(HIT), (exp_idx >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    RST_N   = 1'b0;
    WR_EN   = 1'b0;
    WR_ADDR = '0;
    WR_DATA = '0;
    START   = 1'b0;
    CHAVE   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      vld_m[i] = 1'b0;
    end
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_hit", 32'(HIT), 32'd0);
    check_eq("rst_idx", 32'(INDICE), 32'd0);
`ifdef EQ_SEARCH_COUNT_EN
    check_eq("rst_cnt", 32'(CONTAGEM), 32'd0);
`endif

    run_search("empty", 16'h0000, 0, 16'h0);

    for (int i = 0; i < DEPTH; i++) write_entry(i, 16'(i));
    run_search("seq5", 16'h0005, 0, 16'h0);

    write_entry(2, 16'hBEEF);
    write_entry(6, 16'hBEEF);
    run_search("beef", 16'hBEEF, 0, 16'h0);

    run_search("busy_inj", 16'hCAFE, 1, 16'h0);
    run_search("frozen", 16'hCAFE, 0, 16'h0);

    run_search("abort", 16'h0007, 2, 16'h0);
    run_search("post_abort", 16'h0007, 0, 16'h0);

    run_search("wr_start", 16'h1234, 3, 16'h1234);

    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        write_entry($urandom_range(0, DEPTH - 1), 16'h00A0 + 16'($urandom_range(0, 3)));
      end
      run_search("rand", 16'h00A0 + 16'($urandom_range(0, 4)), 0, 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_search_ctrl.md
EQ_SEARCH_CTRL -- requirements
Module: eq_search_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of table entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have parameter IDX_W, default 3, giving the index width; IDX_W SHALL equal log2(DEPTH).
REQ-003 The block SHALL have port CLK, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, width 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port WR_EN, input, width 1, the table write strobe.
REQ-006 The block SHALL have port WR_ADDR, input, width IDX_W, the table write index.
REQ-007 The block SHALL have port WR_DATA, input, width 16, the table write value.
REQ-008 The block SHALL have port START, input, width 1, the search request.
REQ-009 The block SHALL have port CHAVE, input, width 16, the search key, sampled with START.
REQ-010 The block SHALL have port BUSY, output, width 1, high while a search is in progress.
REQ-011 The block SHALL have port DONE, output, width 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port HIT, output, width 1, set when a valid entry equals the key.
REQ-013 The block SHALL have port INDICE, output, width IDX_W, giving the lowest matching index.

Function
REQ-014 The block SHALL hold DEPTH 16-bit entries, each with a valid bit; a write with WR_EN=1 and BUSY=0 SHALL store WR_DATA at WR_ADDR and set that entry's valid bit.
REQ-015 The block SHALL ignore WR_EN while BUSY=1; the table is frozen during a search.
REQ-016 All comparisons SHALL use exactly one shared 16-bit equality comparator, one entry per cycle.
REQ-017 The FSM SHALL have states OCIOSO, BUSCA and FIM.
REQ-018 In OCIOSO with START=1, the block SHALL latch CHAVE, clear HIT and INDICE, set the pointer to 0 and enter BUSCA.
REQ-019 In BUSCA, each cycle SHALL compare entry[pointer] with the latched key; only valid entries can match.
REQ-020 In BUSCA, the first match SHALL set HIT=1 and INDICE=pointer and go to FIM; with no match at pointer=DEPTH-1, the block SHALL go to FIM with HIT=0; otherwise the pointer SHALL increment.
REQ-021 In FIM, the block SHALL assert DONE for exactly one cycle and return to OCIOSO.
REQ-022 BUSY SHALL be 1 in BUSCA and FIM and 0 in OCIOSO.
REQ-023 Latency: if START is sampled at edge 0 and the match is at entry k, DONE SHALL be high in cycle k+2; with no match, DONE SHALL be high in cycle DEPTH+1.
REQ-024 START while BUSY=1 SHALL be ignored; if START and WR_EN occur together in OCIOSO, the write SHALL complete first and the search SHALL see the new value.
REQ-025 HIT and INDICE SHALL hold their values from DONE until the next accepted START.

Reset
REQ-026 When RST_N=0 at a clock edge, the block SHALL enter OCIOSO, clear all valid bits, and drive BUSY, DONE, HIT, INDICE and CONTAGEM to 0; entry data need not be cleared.
REQ-027 Reset during BUSCA or FIM SHALL abort the search with no DONE pulse.

Configuration
REQ-028 When macro EQ_SEARCH_COUNT_EN is defined, the block SHALL add output CONTAGEM, width IDX_W+1, holding the number of matching valid entries.
REQ-029 With EQ_SEARCH_COUNT_EN defined, BUSCA SHALL always scan all DEPTH entries, DONE SHALL occur in cycle DEPTH+1, and HIT/INDICE SHALL still report the lowest match.
REQ-030 Without EQ_SEARCH_COUNT_EN, the CONTAGEM port and counter SHALL be absent and the search SHALL stop at the first match.

Verification
REQ-031 Write entries 0..7 = 16'h0000..16'h0007, then START with CHAVE=16'h0005 -> DONE in cycle 7, HIT=1, INDICE=5 (count build: CONTAGEM=1, DONE in cycle 9).
REQ-032 After reset with no writes, START with CHAVE=16'h0000 -> HIT=0 in DONE cycle 9, because invalid entries never match.
REQ-033 Write entries 2 and 6 = 16'hBEEF, then search 16'hBEEF -> INDICE=2 (count build: CONTAGEM=2).
REQ-034 During BUSY, WR_EN to entry 7 = key and START again -> both ignored, one DONE, table unchanged.
REQ-035 Apply RST_N=0 in cycle 3 of a search -> no DONE, BUSY=0 next cycle, a subsequent search returns HIT=0.
REQ-036 Apply START and WR_EN (addr 0, 16'h1234) together with CHAVE=16'h1234 -> HIT=1, INDICE=0, DONE in cycle 2.
